// File: rtl/chain_code_pkg.sv
// Shared constants, state encoding and direction helpers for the chain-code
// encoder/decoder pair.
package chain_code_pkg;

    localparam int COORD_W = 6;
    localparam int PERIM_W = 9;
    localparam int CODE_W  = 8;
    localparam int ADDR_W  = 2 * COORD_W;

    localparam logic [PERIM_W-1:0] PERIM_MAX = '1;
    localparam logic [CODE_W-1:0]  END_CODE  = 8'hFF;

    // Freeman directions, row index grows downward
    localparam logic [2:0] DIR_E  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_N  = 3'd2;
    localparam logic [2:0] DIR_NW = 3'd3;
    localparam logic [2:0] DIR_W  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_S  = 3'd6;
    localparam logic [2:0] DIR_SE = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_START,
        RUN,
        DONE,
        ERR
    } state_t;

    function automatic logic signed [1:0] dir_dx(input logic [2:0] dir);
        case (dir)
            DIR_E, DIR_NE, DIR_SE: dir_dx = 2'sb01;
            DIR_NW, DIR_W, DIR_SW: dir_dx = 2'sb11;
            default:               dir_dx = 2'sb00;
        endcase
    endfunction

    function automatic logic signed [1:0] dir_dy(input logic [2:0] dir);
        case (dir)
            DIR_NE, DIR_N, DIR_NW: dir_dy = 2'sb11;
            DIR_SW, DIR_S, DIR_SE: dir_dy = 2'sb01;
            default:               dir_dy = 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/chain_code_step.sv
// Single Freeman step: next coordinate plus a flag when the step would leave
// the IMG_W x IMG_W image.
module chain_code_step
    import chain_code_pkg::*;
#(
    parameter int IMG_W = 64
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         dir,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               out_of_bounds
);

    localparam logic signed [COORD_W+1:0] LIMIT = (COORD_W+2)'(IMG_W);

    logic signed [1:0]         dx;
    logic signed [1:0]         dy;
    logic signed [COORD_W+1:0] sx;
    logic signed [COORD_W+1:0] sy;

    // Two guard bits let both underflow (negative) and overflow be detected
    always_comb begin
        dx = dir_dx(dir);
        dy = dir_dy(dir);
        sx = $signed({2'b00, x}) + $signed({{COORD_W{dx[1]}}, dx});
        sy = $signed({2'b00, y}) + $signed({{COORD_W{dy[1]}}, dy});
        out_of_bounds = sx[COORD_W+1] || sy[COORD_W+1] || (sx >= LIMIT) || (sy >= LIMIT);
        nx = sx[COORD_W-1:0];
        ny = sy[COORD_W-1:0];
    end

endmodule

// File: rtl/chain_code_decoder.sv
// Freeman chain-code decoder: traces a chain from a start pixel and emits one
// bitmap write per accepted direction code.
module chain_code_decoder
    import chain_code_pkg::*;
#(
    parameter int                IMG_W    = 64,
    parameter logic [CODE_W-1:0] END_CODE = chain_code_pkg::END_CODE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] startX,
    input  logic [COORD_W-1:0] startY,
    input  logic [CODE_W-1:0]  code,
    input  logic               code_valid,
    output logic               code_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PERIM_W-1:0] perimeter,
    output logic               closed,
    output logic               done,
    output logic               error
);

    state_t             state;
    logic [COORD_W-1:0] org_x;
    logic [COORD_W-1:0] org_y;
    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;
    logic               step_oob;
    logic               is_dir;
    logic               is_end;

    chain_code_step #(
        .IMG_W(IMG_W)
    ) u_step (
        .x            (pix_x),
        .y            (pix_y),
        .dir          (code[2:0]),
        .nx           (step_x),
        .ny           (step_y),
        .out_of_bounds(step_oob)
    );

    assign is_end  = (code == END_CODE);
    assign is_dir  = (code[CODE_W-1:3] == '0);
    assign wr_addr = {pix_y, pix_x};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            org_x      <= '0;
            org_y      <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_valid  <= 1'b0;
            code_ready <= 1'b0;
            perimeter  <= '0;
            closed     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        org_x     <= startX;
                        org_y     <= startY;
                        pix_x     <= startX;
                        pix_y     <= startY;
                        pix_valid <= 1'b1;
                        perimeter <= '0;
                        closed    <= 1'b0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        state     <= EMIT_START;
                    end
                end
                EMIT_START: begin
                    code_ready <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    // code_ready is high in RUN, so code_valid alone marks a transfer
                    if (code_valid) begin
                        if (is_end) begin
                            done       <= 1'b1;
                            closed     <= (pix_x == org_x) && (pix_y == org_y);
                            code_ready <= 1'b0;
                            state      <= DONE;
                        end else if (!is_dir || step_oob || (perimeter == PERIM_MAX)) begin
                            error      <= 1'b1;
                            code_ready <= 1'b0;
                            state      <= ERR;
                        end else begin
                            pix_x     <= step_x;
                            pix_y     <= step_y;
                            pix_valid <= 1'b1;
                            perimeter <= perimeter + PERIM_W'(1);
                        end
                    end
                end
                default: begin
                    code_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
